// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store unit.
// MISALIGN_TRAP_EN selects trapping versus silent alignment.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t S_IDLE   = 3'd0;
    localparam lsu_state_t S_LOAD   = 3'd1;
    localparam lsu_state_t S_RMW_RD = 3'd2;
    localparam lsu_state_t S_WRITE  = 3'd3;
    localparam lsu_state_t S_RESP   = 3'd4;

    function automatic logic is_fault(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] norm_f3(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: return f3;
            default:                        return F3_W;
        endcase
    endfunction

    // Offset aligned down to the access size of a legal funct3.
    function automatic logic [1:0] norm_off(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        if (f3[1])
            return 2'b00;
        else if (f3[0])
            return {off[1], 1'b0};
        else
            return off;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction for loads and lane merge for sub-word stores.
// Purely combinational.
import lsu_pkg::*;

module lsu_align (
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext,
    output logic [XLEN-1:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{off, 3'b000} +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        ext    = word;
        case (funct3)
            F3_B:    ext = {{24{byte_v[7]}}, byte_v};
            F3_H:    ext = {{16{half_v[15]}}, half_v};
            F3_BU:   ext = {24'd0, byte_v};
            F3_HU:   ext = {16'd0, half_v};
            default: ext = word;
        endcase
    end

    always_comb begin
        merged = wdata;
        if (funct3[1:0] == 2'b00) begin
            merged = word;
            merged[{off, 3'b000} +: 8] = wdata[7:0];
        end else if (funct3[1:0] == 2'b01) begin
            merged = word;
            if (off[1])
                merged[31:16] = wdata[15:0];
            else
                merged[15:0] = wdata[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer with read-modify-write for SB/SH.
// MISALIGN_TRAP_EN: fault misaligned/illegal accesses instead of aligning.
import lsu_pkg::*;

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_t        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   wdata_q;
    logic              we_q;
    logic              fault_q;
    logic [XLEN-1:0]   rdata_q;

    logic              acc_fault;
    logic [2:0]        acc_f3;
    logic [1:0]        acc_off;
    logic [XLEN-1:0]   ext;
    logic [XLEN-1:0]   merged;
    logic              rd_cyc;
    logic              wr_cyc;

`ifdef MISALIGN_TRAP_EN
    assign acc_fault = is_fault(req_funct3, req_addr[1:0]);
    assign acc_f3    = req_funct3;
    assign acc_off   = req_addr[1:0];
`else
    assign acc_fault = 1'b0;
    assign acc_f3    = norm_f3(req_funct3);
    assign acc_off   = norm_off(acc_f3, req_addr[1:0]);
`endif

    lsu_align u_align (
        .word   (mem_rdata),
        .wdata  (wdata_q),
        .off    (addr_q[1:0]),
        .funct3 (f3_q),
        .ext    (ext),
        .merged (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    addr_q  <= {req_addr[ADDR_W-1:2], acc_off};
                    f3_q    <= acc_f3;
                    wdata_q <= req_wdata;
                    we_q    <= req_we;
                    fault_q <= acc_fault;
                    if (acc_fault) begin
                        rdata_q <= '0;
                        state_q <= S_RESP;
                    end else if (!req_we)
                        state_q <= S_LOAD;
                    else if (acc_f3[1:0] == 2'b10)
                        state_q <= S_WRITE;
                    else
                        state_q <= S_RMW_RD;
                end
                S_LOAD: begin
                    rdata_q <= ext;
                    state_q <= S_RESP;
                end
                // Merged word reuses the store-data register.
                S_RMW_RD: begin
                    wdata_q <= merged;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    rdata_q <= '0;
                    state_q <= S_RESP;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_cyc = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    assign wr_cyc = (state_q == S_WRITE) && we_q;

    assign req_ready    = state_q == S_IDLE;
    assign resp_valid   = state_q == S_RESP;
    assign resp_rdata   = rdata_q;
    assign resp_fault   = fault_q;
    assign mem_read_en  = rst_n && rd_cyc;
    assign mem_write_en = rst_n && wr_cyc;
    assign mem_address  = (rd_cyc || wr_cyc)
                        ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata    = wr_cyc ? wdata_q : '0;

endmodule
